cdma_img_line_req_gen: RTL and testbench

- Upstream neighbour of the CDMA image-path 11-bit tag FIFO (128x11, valid/ready write side).
- Walks an image surface line by line and splits each line into 32-byte-atom DMA read requests, at most MAX_ATOMS atoms each, never crossing a 256B boundary.
- Issues each request on the DMA read-request port and pushes a matching 11-bit tag into the tag FIFO.
- The downstream pixel packer pops the FIFO to interpret returning read data.

---
 rtl/cdma_img_line_req_gen.sv | 249 ++++++++++++++++++++++++
 tb/tb_cdma_img_line_req_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdma_img_line_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : cdma_img_line_req_gen
// Purpose  : Walks an image surface line by line, splitting every line into
//            32-byte-atom DMA read requests (at most MAX_ATOMS atoms, never
//            crossing a 256B boundary) and pushing a matching 11-bit tag
//            {last_req, line_end, size_m1[2:0], seq[5:0]} into the tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module cdma_img_line_req_gen #(
  parameter int MAX_ATOMS = 8,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_en,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_line_stride,
  input  logic [11:0]       cfg_line_atoms,
  input  logic [12:0]       cfg_height_m1,
  output logic              dma_rd_req_valid,
  input  logic              dma_rd_req_ready,
  output logic [ADDR_W-1:0] dma_rd_req_addr,
  output logic [3:0]        dma_rd_req_size,
  output logic              tag_wr_req,
  input  logic              tag_wr_ready,
  output logic [10:0]       tag_wr_data,
  output logic              busy,
  output logic              op_done
);

  localparam logic [3:0] MAX_ATOMS_C = 4'(MAX_ATOMS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Walk state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [12:0]       line_cnt_q, line_cnt_d;
  logic [11:0]       atoms_left_q, atoms_left_d;
  logic [5:0]        seq_q, seq_d;

  // Configuration captured at operation start
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [11:0]       line_atoms_q, line_atoms_d;
  logic [12:0]       height_m1_q, height_m1_d;

  // Request/tag pair currently presented; the valid flags double as the
  // per-side "not yet accepted" flags once a pair has been issued.
  logic              issued_q, issued_d;
  logic              dma_valid_q, dma_valid_d;
  logic              tag_valid_q, tag_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [3:0]        req_size_q, req_size_d;
  logic [10:0]       tag_data_q, tag_data_d;
  logic              busy_q, busy_d;
  logic              op_done_q, op_done_d;

  // Helpers
  logic              load;
  logic              pair_done;
  logic [3:0]        cur_atoms;
  logic [3:0]        new_atoms;
  logic [3:0]        new_size_m1;
  logic              new_line_end;
  logic              new_last;
  logic [11:0]       cfg_atoms_eff;

  // Low address bits are defined as ignored; fold them away explicitly.
  logic              unused_cfg_low_bits;
  assign unused_cfg_low_bits = ^{cfg_base_addr[4:0], cfg_line_stride[4:0]};

  // Atoms in the next request: limited by what is left of the line, by the
  // per-request maximum and by the room left before the next 256B boundary.
  function automatic logic [3:0] calc_atoms(input logic [2:0]  blk,
                                            input logic [11:0] left);
    logic [3:0] room;
    logic [3:0] a;
    room = 4'd8 - {1'b0, blk};
    a    = MAX_ATOMS_C;
    if (room < a) a = room;
    if ({8'd0, a} > left) a = left[3:0];
    return a;
  endfunction

  assign cfg_atoms_eff = (cfg_line_atoms == 12'd0) ? 12'd1 : cfg_line_atoms;

  // The presented pair retires once each side has been accepted, either in
  // an earlier cycle (valid already dropped) or in this one.
  assign pair_done = (state_q == ST_REQ) && issued_q &&
                     (!dma_valid_q || dma_rd_req_ready) &&
                     (!tag_valid_q || tag_wr_ready);

  // Size of the pair currently presented, recovered from its tag.
  assign cur_atoms = {1'b0, tag_data_q[8:6]} + 4'd1;

  // Next-state logic: FSM, address walk, and computation of the next pair
  // directly into the output registers so a new pair follows every cycle.
  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    cur_addr_d   = cur_addr_q;
    line_cnt_d   = line_cnt_q;
    atoms_left_d = atoms_left_q;
    seq_d        = seq_q;
    stride_d     = stride_q;
    line_atoms_d = line_atoms_q;
    height_m1_d  = height_m1_q;
    issued_d     = issued_q;
    dma_valid_d  = dma_valid_q;
    tag_valid_d  = tag_valid_q;
    req_addr_d   = req_addr_q;
    req_size_d   = req_size_q;
    tag_data_d   = tag_data_q;
    op_done_d    = 1'b0;
    load         = 1'b0;
    new_atoms    = 4'd0;
    new_size_m1  = 4'd0;
    new_line_end = 1'b0;
    new_last     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dma_valid_d = 1'b0;
        tag_valid_d = 1'b0;
        issued_d    = 1'b0;
        if (op_en) begin
          state_d      = ST_REQ;
          stride_d     = {cfg_line_stride[ADDR_W-1:5], 5'd0};
          line_atoms_d = cfg_atoms_eff;
          height_m1_d  = cfg_height_m1;
          line_addr_d  = {cfg_base_addr[ADDR_W-1:5], 5'd0};
          cur_addr_d   = {cfg_base_addr[ADDR_W-1:5], 5'd0};
          line_cnt_d   = 13'd0;
          atoms_left_d = cfg_atoms_eff;
        end
      end

      ST_REQ: begin
        if (!issued_q) begin
          // First cycle of the operation: build the first pair.
          load = 1'b1;
        end else if (pair_done) begin
          seq_d       = seq_q + 6'd1;
          dma_valid_d = 1'b0;
          tag_valid_d = 1'b0;
          issued_d    = 1'b0;
          if (tag_data_q[10]) begin
            state_d   = ST_DONE;
            op_done_d = 1'b1;
          end else if (tag_data_q[9]) begin
            line_addr_d  = line_addr_q + stride_q;
            cur_addr_d   = line_addr_q + stride_q;
            atoms_left_d = line_atoms_q;
            line_cnt_d   = line_cnt_q + 13'd1;
            load         = 1'b1;
          end else begin
            cur_addr_d   = cur_addr_q + ({{(ADDR_W-4){1'b0}}, cur_atoms} << 5);
            atoms_left_d = atoms_left_q - {8'd0, cur_atoms};
            load         = 1'b1;
          end
        end else begin
          // Partial acceptance: retire whichever side was taken this cycle.
          if (dma_rd_req_ready) dma_valid_d = 1'b0;
          if (tag_wr_ready)     tag_valid_d = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      new_atoms    = calc_atoms(cur_addr_d[7:5], atoms_left_d);
      new_size_m1  = new_atoms - 4'd1;
      new_line_end = ({8'd0, new_atoms} == atoms_left_d);
      new_last     = new_line_end && (line_cnt_d == height_m1_q);
      req_addr_d   = cur_addr_d;
      req_size_d   = new_size_m1;
      tag_data_d   = {new_last, new_line_end, new_size_m1[2:0], seq_d};
      dma_valid_d  = 1'b1;
      tag_valid_d  = 1'b1;
      issued_d     = 1'b1;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_addr_q  <= '0;
      cur_addr_q   <= '0;
      line_cnt_q   <= '0;
      atoms_left_q <= '0;
      seq_q        <= '0;
      stride_q     <= '0;
      line_atoms_q <= '0;
      height_m1_q  <= '0;
      issued_q     <= 1'b0;
      dma_valid_q  <= 1'b0;
      tag_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_size_q   <= '0;
      tag_data_q   <= '0;
      busy_q       <= 1'b0;
      op_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      cur_addr_q   <= cur_addr_d;
      line_cnt_q   <= line_cnt_d;
      atoms_left_q <= atoms_left_d;
      seq_q        <= seq_d;
      stride_q     <= stride_d;
      line_atoms_q <= line_atoms_d;
      height_m1_q  <= height_m1_d;
      issued_q     <= issued_d;
      dma_valid_q  <= dma_valid_d;
      tag_valid_q  <= tag_valid_d;
      req_addr_q   <= req_addr_d;
      req_size_q   <= req_size_d;
      tag_data_q   <= tag_data_d;
      busy_q       <= busy_d;
      op_done_q    <= op_done_d;
    end
  end

  assign dma_rd_req_valid = dma_valid_q;
  assign dma_rd_req_addr  = req_addr_q;
  assign dma_rd_req_size  = req_size_q;
  assign tag_wr_req       = tag_valid_q;
  assign tag_wr_data      = tag_data_q;
  assign busy             = busy_q;
  assign op_done          = op_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cdma_img_line_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdma_img_line_req_gen
// Purpose  : Self-checking bench for cdma_img_line_req_gen. A queue-based
//            model of the surface walk predicts every request and tag; a
//            negedge monitor compares each accepted transfer, hold stability,
//            busy and op_done against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdma_img_line_req_gen;

  localparam int MAXA = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_en;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_line_stride;
  logic [11:0] cfg_line_atoms;
  logic [12:0] cfg_height_m1;
  logic        dma_rd_req_valid;
  logic        dma_rd_req_ready;
  logic [31:0] dma_rd_req_addr;
  logic [3:0]  dma_rd_req_size;
  logic        tag_wr_req;
  logic        tag_wr_ready;
  logic [10:0] tag_wr_data;
  logic        busy;
  logic        op_done;

  always #5 clk = ~clk;

  cdma_img_line_req_gen #(.MAX_ATOMS(MAXA), .ADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .op_en            (op_en),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_line_stride  (cfg_line_stride),
    .cfg_line_atoms   (cfg_line_atoms),
    .cfg_height_m1    (cfg_height_m1),
    .dma_rd_req_valid (dma_rd_req_valid),
    .dma_rd_req_ready (dma_rd_req_ready),
    .dma_rd_req_addr  (dma_rd_req_addr),
    .dma_rd_req_size  (dma_rd_req_size),
    .tag_wr_req       (tag_wr_req),
    .tag_wr_ready     (tag_wr_ready),
    .tag_wr_data      (tag_wr_data),
    .busy             (busy),
    .op_done          (op_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  size;
    logic [10:0] tag;
  } pair_t;

  pair_t exp_dma[$];
  pair_t exp_tag[$];
  int    model_seq = 0;

  int vectors     = 0;
  int miscompares = 0;
  bit rand_rdy    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Surface walk model: every line starts at base + line*stride and is cut
  // into chunks limited by atoms remaining, MAXA and the 256B boundary.
  task automatic build_model(input logic [31:0] base, input logic [31:0] stride,
                             input logic [11:0] la, input logic [12:0] hm1);
    logic [31:0] a;
    logic [31:0] s;
    logic [31:0] b;
    int          left, room, n, eff;
    logic        lend, llast;
    pair_t       p;
    eff = (la == 12'd0) ? 1 : int'(la);
    b   = base & 32'hFFFF_FFE0;
    s   = stride & 32'hFFFF_FFE0;
    for (int line = 0; line <= int'(hm1); line++) begin
      a    = b + 32'(line) * s;
      left = eff;
      while (left > 0) begin
        room   = 8 - int'(a[7:5]);
        n      = left;
        if (n > MAXA) n = MAXA;
        if (n > room) n = room;
        lend   = (n == left);
        llast  = lend && (line == int'(hm1));
        p.addr = a;
        p.size = 4'(n - 1);
        p.tag  = {llast, lend, 3'(n - 1), 6'(model_seq)};
        exp_dma.push_back(p);
        exp_tag.push_back(p);
        model_seq = (model_seq + 1) % 64;
        a    = a + 32'(n * 32);
        left = left - n;
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic        busy_exp = 1'b0;
  logic        done_exp = 1'b0;
  logic        dma_hold = 1'b0;
  logic        tag_hold = 1'b0;
  logic [31:0] held_addr;
  logic [3:0]  held_size;
  logic [10:0] held_tag;
  logic        m_df, m_tf, m_new_done;
  pair_t       m_pop;
  int          dma_fire_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_size = '0;
  logic [10:0] last_tag  = '0;

  always @(negedge clk) begin
    if (reset) begin
      busy_exp = 1'b0;
      done_exp = 1'b0;
      dma_hold = 1'b0;
      tag_hold = 1'b0;
    end else begin
      check("busy", busy, busy_exp);
      check("op_done", op_done, done_exp);
      if (!busy_exp) begin
        check("idle_dma_valid", dma_rd_req_valid, 1'b0);
        check("idle_tag_req", tag_wr_req, 1'b0);
      end
      if (dma_hold) begin
        check("dma_hold_valid", dma_rd_req_valid, 1'b1);
        check("dma_hold_addr", dma_rd_req_addr, held_addr);
        check("dma_hold_size", dma_rd_req_size, held_size);
      end
      if (tag_hold) begin
        check("tag_hold_req", tag_wr_req, 1'b1);
        check("tag_hold_data", tag_wr_data, held_tag);
      end
      m_df = dma_rd_req_valid && dma_rd_req_ready;
      m_tf = tag_wr_req && tag_wr_ready;
      if (m_df) begin
        dma_fire_cnt++;
        last_addr = dma_rd_req_addr;
        last_size = dma_rd_req_size;
        if (exp_dma.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dma_extra_request: got addr 0x%0h, no request expected", dma_rd_req_addr);
        end else begin
          m_pop = exp_dma.pop_front();
          check("dma_addr", dma_rd_req_addr, m_pop.addr);
          check("dma_size", dma_rd_req_size, m_pop.size);
        end
      end
      if (m_tf) begin
        last_tag = tag_wr_data;
        if (exp_tag.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tag_extra_write: got 0x%0h, no tag expected", tag_wr_data);
        end else begin
          m_pop = exp_tag.pop_front();
          check("tag_data", tag_wr_data, m_pop.tag);
        end
      end
      dma_hold  = dma_rd_req_valid && !dma_rd_req_ready;
      tag_hold  = tag_wr_req && !tag_wr_ready;
      held_addr = dma_rd_req_addr;
      held_size = dma_rd_req_size;
      held_tag  = tag_wr_data;
      m_new_done = busy_exp && (m_df || m_tf) && (exp_dma.size() == 0) && (exp_tag.size() == 0);
      if (done_exp)               busy_exp = 1'b0;
      else if (!busy_exp && op_en) busy_exp = 1'b1;
      done_exp = m_new_done;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      dma_rd_req_ready = ($urandom % 4) != 0;
      tag_wr_ready     = ($urandom % 4) != 0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_dma.delete();
    exp_tag.delete();
    model_seq = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic start_op(input logic [31:0] base, input logic [31:0] stride,
                          input logic [11:0] la, input logic [12:0] hm1);
    build_model(base, stride, la, hm1);
    cfg_base_addr   = base;
    cfg_line_stride = stride;
    cfg_line_atoms  = la;
    cfg_height_m1   = hm1;
    op_en = 1'b1;
    step();
    op_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      n++;
      step();
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL op_timeout: busy still 1 after %0d cycles, required 0", budget);
      apply_reset();
    end
    check("dma_queue_drained", exp_dma.size(), 0);
    check("tag_queue_drained", exp_tag.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset            = 1'b1;
    op_en            = 1'b0;
    cfg_base_addr    = '0;
    cfg_line_stride  = '0;
    cfg_line_atoms   = '0;
    cfg_height_m1    = '0;
    dma_rd_req_ready = 1'b0;
    tag_wr_ready     = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_dma_valid", dma_rd_req_valid, 1'b0);
    check("rst_tag_req", tag_wr_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_done", op_done, 1'b0);
    check("rst_addr", dma_rd_req_addr, 32'h0);
    check("rst_size", dma_rd_req_size, 4'h0);
    check("rst_tag", tag_wr_data, 11'h0);

    dma_rd_req_ready = 1'b1;
    tag_wr_ready     = 1'b1;

    // Single pair
    apply_reset();
    start_op(32'h1000, 32'h0, 12'd3, 13'd0);
    check("t1_model_addr", exp_dma[0].addr, 32'h1000);
    check("t1_model_tag", exp_tag[0].tag, 11'h680);
    wait_done(50, n);
    check("t1_busy_cycles", n, 3);
    check("t1_dut_addr", last_addr, 32'h1000);
    check("t1_dut_size", last_size, 4'd2);
    check("t1_dut_tag", last_tag, 11'h680);

    // Boundary split
    apply_reset();
    start_op(32'h10C0, 32'h0, 12'd10, 13'd0);
    check("t2_model_tag0", exp_tag[0].tag, 11'h040);
    check("t2_model_size0", exp_dma[0].size, 4'd1);
    check("t2_model_addr1", exp_dma[1].addr, 32'h1100);
    check("t2_model_tag1", exp_tag[1].tag, 11'h7C1);
    wait_done(50, n);
    check("t2_busy_cycles", n, 4);
    check("t2_dut_addr", last_addr, 32'h1100);
    check("t2_dut_tag", last_tag, 11'h7C1);

    // Two lines with stride
    apply_reset();
    start_op(32'h0, 32'h2000, 12'd8, 13'd1);
    check("t3_model_tag0", exp_tag[0].tag, 11'h3C0);
    check("t3_model_addr1", exp_dma[1].addr, 32'h2000);
    wait_done(50, n);
    check("t3_busy_cycles", n, 4);
    check("t3_dut_addr", last_addr, 32'h2000);
    check("t3_dut_tag", last_tag, 11'h7C1);

    // Tag FIFO full stall
    apply_reset();
    start_op(32'h500, 32'h100, 12'd3, 13'd1);
    dma_rd_req_ready = 1'b1;
    tag_wr_ready     = 1'b0;
    dma_fire_cnt     = 0;
    repeat (5) step();
    check("stall_dma_fires", dma_fire_cnt, 1);
    check("stall_dma_valid", dma_rd_req_valid, 1'b0);
    check("stall_tag_req", tag_wr_req, 1'b1);
    check("stall_tag_data", tag_wr_data, 11'h280);
    tag_wr_ready = 1'b1;
    wait_done(50, n);
    check("stall_total_dma_fires", dma_fire_cnt, 2);

    // 65 single-atom pairs: sequence wrap
    apply_reset();
    start_op(32'h8000, 32'h20, 12'd1, 13'd64);
    check("seq_model_tag63", exp_tag[63].tag, 11'h23F);
    check("seq_model_tag64", exp_tag[64].tag, 11'h600);
    wait_done(200, n);
    check("seq_busy_cycles", n, 67);
    check("seq_dut_last_tag", last_tag, 11'h600);

    // Reset during the third pair of a ten-pair operation
    apply_reset();
    start_op(32'h3000, 32'h40, 12'd1, 13'd9);
    repeat (3) step();
    tag_wr_ready = 1'b0;
    step();
    reset = 1'b1;
    exp_dma.delete();
    exp_tag.delete();
    model_seq = 0;
    step();
    reset = 1'b0;
    check("abort_dma_valid", dma_rd_req_valid, 1'b0);
    check("abort_tag_req", tag_wr_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    tag_wr_ready = 1'b1;
    start_op(32'h3000, 32'h40, 12'd2, 13'd0);
    wait_done(50, n);
    check("restart_addr", last_addr, 32'h3000);
    check("restart_tag", last_tag, 11'h640);

    // Maximum height with address wrap-around
    start_op(32'hFFFF_F000, 32'h20, 12'd1, 13'd8191);
    wait_done(9000, n);
    check("tall_busy_cycles", n, 8194);

    // Randomized operations with random back-pressure and ignored op_en
    rand_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      start_op($urandom, $urandom, 12'($urandom_range(0, 40)), 13'($urandom_range(0, 5)));
      cfg_base_addr   = $urandom;
      cfg_line_stride = $urandom;
      cfg_line_atoms  = 12'($urandom);
      cfg_height_m1   = 13'($urandom);
      op_en = 1'b1;
      step();
      op_en = 1'b0;
      wait_done(20000, n);
    end
    rand_rdy = 1'b0;
    dma_rd_req_ready = 1'b1;
    tag_wr_ready     = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
